// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
package loader_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam logic [7:0]  SYNC_BYTE            = 8'hA5;

    // Loader frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN,
        S_FAIL
    } state_t;

    // UART receiver bit-timing states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, framing-error flag.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int unsigned   CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev_q;

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          ferr_q, ferr_d;

    assign rx_s     = sync_q[1];
    assign rx_valid = valid_q;
    assign rx_data  = data_q;
    assign rx_ferr  = ferr_q;

    // Metastability synchronizer and previous-sample register for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: start on falling edge, confirm start at mid-bit, sample data/stop mid-bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    ferr_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Loads instruction memory from a UART frame (A5, N, N little-endian words) while holding the core.
// Optional feature: LOADER_CHECKSUM_EN expects a trailing XOR-of-data checksum byte.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned MEM_WORDS    = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX,
    output logic        WE,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        CORE_HOLD,
    output logic        DONE,
    output logic        ERR
);

    localparam int unsigned IW = $clog2(MEM_WORDS + 1);

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ferr;

    state_t        state_q, state_d;
    logic [IW-1:0] n_q, n_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   word_q, word_d;
    logic          we_q, we_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   wd_q, wd_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    assign WE        = we_q;
    assign A         = a_q;
    assign WD        = wd_q;
    assign CORE_HOLD = hold_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (CLK),
        .rst_n    (RST_N),
        .rx       (RX),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    // Loader state and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            we_q    <= we_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Frame sequencing; WE/A/WD are loaded on entry to WRITE so the strobe aligns with that state
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        we_d    = 1'b0;
        a_d     = a_q;
        wd_d    = wd_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && !rx_ferr && (rx_data == SYNC_BYTE)) begin
                    state_d = S_LEN;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (!rx_ferr && (rx_data != 8'd0) && (32'(rx_data) <= MEM_WORDS)) begin
                        state_d = S_DATA;
                        n_d     = IW'(rx_data);
                        idx_d   = '0;
                        bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (rx_ferr) begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end else begin
                        word_d = {rx_data, word_q[31:8]};
                        bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_d = csum_q ^ rx_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            state_d = S_WRITE;
                            we_d    = 1'b1;
                            a_d     = 32'({idx_q, 2'b00});
                            wd_d    = word_d;
                        end
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + IW'(1);
                if ((idx_q + IW'(1)) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FIN;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (!rx_ferr && (rx_data == csum_q)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            S_FIN: begin
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning CLK cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter MEM_WORDS, default 20, meaning instruction-memory depth in 32-bit words.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  system clock; all state on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 RX  input  1  UART serial in, 8N1, idle high, LSB first.
REQ-007 WE  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-008 A  output  32  byte address of the word being written, word-aligned.
REQ-009 WD  output  32  word being written.
REQ-010 CORE_HOLD  output  1  high while a load is in progress; holds the core in reset.
REQ-011 DONE  output  1  high after a successful load until the next sync byte.
REQ-012 ERR  output  1  high after a failed load until the next sync byte.

Function
REQ-013 Frame SHALL be: sync 0xA5, count N, then N*4 data bytes, each word little-endian (first byte to WD[7:0]).
REQ-014 States SHALL be IDLE, LEN, DATA, WRITE, [CSUM], FIN, FAIL.
REQ-015 IDLE: a received 0xA5 SHALL go to LEN, set CORE_HOLD=1 and clear DONE/ERR; any other byte is ignored.
REQ-016 LEN: N in 1..MEM_WORDS SHALL latch N, clear the word index and byte counter, and go to DATA; N=0 or N>MEM_WORDS SHALL go to FAIL.
REQ-017 DATA: each byte SHALL shift into the word register; after the 4th byte the next state SHALL be WRITE.
REQ-018 WRITE SHALL last exactly one cycle, with WE=1, A={index,2'b00} and WD=the assembled word; the index then increments.
REQ-019 After the write of word N-1, WRITE SHALL go to FIN (or CSUM when compiled in); otherwise back to DATA.
REQ-020 FIN SHALL set DONE=1, drop CORE_HOLD one cycle later, and return to IDLE.
REQ-021 FAIL SHALL set ERR=1, keep CORE_HOLD=1, and return to IDLE; the core stays held until a later load succeeds.
REQ-022 Outside WRITE, WE SHALL be 0 and A/WD SHALL hold their last values.
REQ-023 A byte with a framing error (stop bit 0) SHALL be discarded in IDLE and SHALL force FAIL in any other state.
REQ-024 A 0xA5 byte received in LEN or DATA SHALL be treated as data or count, not as a resync.
REQ-025 The RX sampler SHALL detect the start bit on a falling edge, re-check it at mid-bit, and sample each data bit at mid-bit. A start bit that is high at mid-bit SHALL be rejected.
REQ-026 RX SHALL pass through a 2-flop synchronizer before any use.

Reset
REQ-027 RST_N low SHALL asynchronously force IDLE, WE=0, A=0, WD=0, CORE_HOLD=0, DONE=0 and ERR=0, and clear all counters. Reset during a load SHALL abandon it with no further writes.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: the frame SHALL end with one byte equal to the XOR of all data bytes. CSUM SHALL go to FIN on a match and to FAIL on a mismatch (words already written stay written).
REQ-029 Macro LOADER_CHECKSUM_EN undefined: the CSUM state and the checksum register SHALL not exist, and WRITE of the last word SHALL go directly to FIN.

Structure
REQ-030 Package loader_pkg SHALL hold the state enum, SYNC_BYTE=8'hA5 and the default CLKS_PER_BIT.
REQ-031 Bit timing SHALL live in sub-module uart_rx, with outputs rx_valid (one-cycle pulse), rx_data[7:0] and rx_ferr.

Verification
REQ-032 CLKS_PER_BIT=4; send A5 02 13 00 00 00 B3 00 50 00 -> WE pulses at A=0 with WD=00000013 and at A=4 with WD=005000B3; DONE=1; CORE_HOLD falls.
REQ-033 Send A5 15 -> ERR=1, no WE pulse, CORE_HOLD stays 1. Then send a valid 1-word frame -> DONE=1, ERR=0, CORE_HOLD=0.
REQ-034 Send 3C 5A then a valid frame -> the leading bytes are ignored and the load succeeds.
REQ-035 Assert RST_N low after 2 of 4 data bytes -> all outputs return to reset values and no WE pulse occurs.
REQ-036 Corrupt the stop bit of the 3rd data byte -> ERR=1 and no WE for that word.
REQ-037 With LOADER_CHECKSUM_EN, send a 1-word frame 13 00 00 00 with checksum 13 -> DONE=1; with checksum 12 -> ERR=1, word 0 written, CORE_HOLD=1.
